date_set_ctrl: RTL

// - Button-driven set-mode sequencer for the date counter: snapshots the running date, lets the user edit day/month/year,

---
 rtl/date_pkg.sv | 51 +++++
 rtl/bcd_field_inc.sv | 22 ++
 rtl/date_set_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/date_pkg.sv
// Shared types, encodings and calendar helpers for the date set-mode sequencer.
package date_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET_DAY,
        SET_MONTH,
        SET_YEAR,
        COMMIT
    } state_t;

    localparam logic [1:0] FSEL_NONE  = 2'b00;
    localparam logic [1:0] FSEL_DAY   = 2'b01;
    localparam logic [1:0] FSEL_MONTH = 2'b10;
    localparam logic [1:0] FSEL_YEAR  = 2'b11;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b10;

    localparam logic [7:0] MON_JAN = 8'h01;
    localparam logic [7:0] MON_FEB = 8'h02;
    localparam logic [7:0] MON_APR = 8'h04;
    localparam logic [7:0] MON_JUN = 8'h06;
    localparam logic [7:0] MON_SEP = 8'h09;
    localparam logic [7:0] MON_NOV = 8'h11;
    localparam logic [7:0] MON_DEC = 8'h12;

    localparam logic [23:0] DATE_RESET = 24'h01_01_00;

    // yy is BCD 00..99 meaning 2000..2099, so divisibility by 4 is decided by
    // the parity of the tens digit together with the units digit.
    function automatic logic is_leap(input logic [7:0] yy);
        logic [3:0] units;
        units = yy[3:0];
        if (yy[4])
            return (units == 4'd2) || (units == 4'd6);
        else
            return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
    endfunction

    function automatic logic [7:0] max_day(input logic [7:0] mm, input logic [7:0] yy);
        logic [7:0] res;
        case (mm)
            MON_FEB:                            res = is_leap(yy) ? 8'h29 : 8'h28;
            MON_APR, MON_JUN, MON_SEP, MON_NOV: res = 8'h30;
            default:                            res = 8'h31;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bcd_field_inc.sv
// Two-digit BCD increment that wraps back to a minimum once the maximum is reached.
module bcd_field_inc
    import date_pkg::*;
(
    input  logic [7:0] value,
    input  logic [7:0] min,
    input  logic [7:0] max,
    output logic [7:0] next
);

    // Values at or above the limit (including out-of-range snapshots) wrap to min.
    always_comb begin
        next = min;
        if (value < max) begin
            if (value[3:0] >= 4'd9)
                next = {value[7:4] + 4'd1, 4'd0};
            else
                next = {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/date_set_ctrl.sv
// Button-driven date edit sequencer: snapshot, edit day/month/year, commit to the date counter.
module date_set_ctrl
    import date_pkg::*;
#(
    parameter int unsigned COMMIT_CYC = 2,
    parameter logic [31:0] TIMEOUT    = 32'd6000,
    parameter logic [15:0] BLINK_DIV  = 16'd500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic [23:0] date_cur,
    output logic [1:0]  date_mode,
    output logic [23:0] date_set,
    output logic [1:0]  field_sel,
    output logic        blink
);

    state_t      state, next_state;
    logic [31:0] to_cnt;
    logic [31:0] commit_cnt;
    logic [15:0] blink_cnt;
    logic        in_set, next_in_set, any_btn, timeout_hit, commit_done, do_inc;
    logic [7:0]  day, month, year;
    logic [7:0]  inc_val, inc_min, inc_max, inc_next;
    logic [7:0]  new_day, new_month, new_year, clamp_max;

    assign {day, month, year} = date_set;
    assign in_set      = state inside {SET_DAY, SET_MONTH, SET_YEAR};
    assign next_in_set = next_state inside {SET_DAY, SET_MONTH, SET_YEAR};
    assign any_btn     = btn_mode | btn_sel | btn_inc;
    assign timeout_hit = (to_cnt == TIMEOUT - 32'd1);
    assign commit_done = (commit_cnt == COMMIT_CYC - 1);
    // btn_inc only acts when it wins the priority contest in a SET_* state.
    assign do_inc      = in_set & ~btn_mode & ~btn_sel & btn_inc;

    // Route the selected field and its legal range to the single incrementer.
    always_comb begin
        inc_val = day;
        inc_min = 8'h01;
        inc_max = max_day(month, year);
        case (state)
            SET_MONTH: begin
                inc_val = month;
                inc_min = MON_JAN;
                inc_max = MON_DEC;
            end
            SET_YEAR: begin
                inc_val = year;
                inc_min = 8'h00;
                inc_max = 8'h99;
            end
            default: ;
        endcase
    end

    bcd_field_inc u_field_inc (
        .value (inc_val),
        .min   (inc_min),
        .max   (inc_max),
        .next  (inc_next)
    );

    // Merge the incremented field back in; month/year edits pull the day down if it no longer fits.
    always_comb begin
        new_day   = day;
        new_month = month;
        new_year  = year;
        case (state)
            SET_DAY:   new_day   = inc_next;
            SET_MONTH: new_month = inc_next;
            SET_YEAR:  new_year  = inc_next;
            default: ;
        endcase
        clamp_max = max_day(new_month, new_year);
        if (state != SET_DAY && new_day > clamp_max)
            new_day = clamp_max;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic with btn_mode > btn_sel > btn_inc priority.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:
                if (btn_mode) next_state = SET_DAY;
            SET_DAY, SET_MONTH, SET_YEAR:
                if (btn_mode)
                    next_state = COMMIT;
                else if (btn_sel)
                    next_state = (state == SET_DAY)   ? SET_MONTH :
                                 (state == SET_MONTH) ? SET_YEAR  : SET_DAY;
                else if (!btn_inc && timeout_hit)
                    next_state = IDLE;
            COMMIT:
                if (commit_done) next_state = IDLE;
            default:
                next_state = IDLE;
        endcase
    end

    // Field indicator decoded from the current state.
    always_comb begin
        field_sel = FSEL_NONE;
        case (state)
            SET_DAY:   field_sel = FSEL_DAY;
            SET_MONTH: field_sel = FSEL_MONTH;
            SET_YEAR:  field_sel = FSEL_YEAR;
            default: ;
        endcase
    end

    // Load strobe is registered so it is glitch-free and aligned with COMMIT occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            date_mode <= MODE_HOLD;
        else
            date_mode <= (next_state == COMMIT) ? MODE_LOAD : MODE_HOLD;
    end

    // Shadow date: snapshot on entry, updated only by a winning increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            date_set <= DATE_RESET;
        else if (state == IDLE && btn_mode)
            date_set <= date_cur;
        else if (do_inc)
            date_set <= {new_day, new_month, new_year};
    end

    // Inactivity counter: runs only while editing with no buttons and no state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (!in_set || any_btn || next_state != state)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 32'd1;
    end

    // Counts cycles spent in COMMIT so the load strobe lasts exactly COMMIT_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            commit_cnt <= '0;
        else if (state == COMMIT && !commit_done)
            commit_cnt <= commit_cnt + 32'd1;
        else
            commit_cnt <= '0;
    end

    // Blink restarts high on every SET_* entry, then toggles every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (next_in_set && next_state != state) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (next_in_set) begin
            if (blink_cnt == BLINK_DIV - 16'd1) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end else begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end
    end

endmodule
